// File: rtl/mips_iter_divider_pkg.sv
// Shared definitions for the iterative MIPS DIV/DIVU unit.
package mips_iter_divider_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/mips_iter_divider_div_restore_step.sv
// One combinational radix-2 restoring step on the packed {R,Q} pair.
module div_restore_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH:0]  rq_in,
    input  logic [WIDTH-1:0]  dvs_mag,
    output logic [2*WIDTH:0]  rq_out
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rq_in[2*WIDTH-1:0], 1'b0};
        // Extra top bit carries the borrow; clear means the trial subtract fits
        diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, dvs_mag};
        rq_out  = shifted;
        if (!diff[WIDTH+1]) begin
            rq_out = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/mips_iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up at the end.
module mips_iter_divider
    import mips_iter_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Start,
    input  logic             Sign,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*WIDTH:0] rq_q, rq_d, rq_step;
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic [WIDTH-1:0] dividend_q, dividend_d, divisor_q, divisor_d;
    logic             sign_q, sign_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic             busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, q_raw, r_raw;

    assign dvd_mag = (sign_q && dividend_q[WIDTH-1]) ? -dividend_q : dividend_q;
    assign dvs_mag = (sign_q && divisor_q[WIDTH-1])  ? -divisor_q  : divisor_q;
    assign q_raw   = rq_q[WIDTH-1:0];
    assign r_raw   = rq_q[2*WIDTH-1:WIDTH];

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rq_in   (rq_q),
        .dvs_mag (dvs_mag_q),
        .rq_out  (rq_step)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rq_d       = rq_q;
        dvs_mag_d  = dvs_mag_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        sign_d     = sign_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        busy_d     = busy_q;
        done_d     = done_q;
        divzero_d  = divzero_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        if (En) begin
            done_d = 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (Start) begin
                        sign_d     = Sign;
                        dividend_d = Dividend;
                        divisor_d  = Divisor;
                        state_d    = PREP;
                    end
                end
                PREP: begin
                    rq_d      = {{(WIDTH+1){1'b0}}, dvd_mag};
                    dvs_mag_d = dvs_mag;
                    qneg_d    = sign_q & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
                    rneg_d    = sign_q & dividend_q[WIDTH-1];
                    cnt_d     = '0;
                    state_d   = ITER;
                end
                ITER: begin
                    rq_d  = rq_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
                end
                FIX: begin
                    // Zero divisor overrides the sign fix-up so the remainder is the raw dividend
                    divzero_d = (divisor_q == '0);
                    if (divisor_q == '0) begin
                        quot_d = '1;
                        rem_d  = dividend_q;
                    end else begin
                        quot_d = qneg_q ? -q_raw : q_raw;
                        rem_d  = rneg_q ? -r_raw : r_raw;
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
            busy_d = (state_d == PREP) || (state_d == ITER) || (state_d == FIX);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rq_q       <= '0;
            dvs_mag_q  <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            sign_q     <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            divzero_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rq_q       <= rq_d;
            dvs_mag_q  <= dvs_mag_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            sign_q     <= sign_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            divzero_q  <= divzero_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivZero   = divzero_q;

endmodule

// File: tb/tb_mips_iter_divider.sv
// Directed-vector bench for mips_iter_divider with hand-computed expectations.
module tb_mips_iter_divider;

    logic        Clk = 1'b0;
    logic        Reset, En, Start, Sign;
    logic [31:0] Dividend, Divisor;
    logic        Busy, Done, DivZero;
    logic [31:0] Quotient, Remainder;

    int n_cmp = 0;
    int n_err = 0;

    mips_iter_divider #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .En        (En),
        .Start     (Start),
        .Sign      (Sign),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Start one division; optional stray Start pulse and En-low window, counted in cycles after Start.
    task automatic run_div(input logic sgn, input logic [31:0] dvd, input logic [31:0] dvs,
                           input int glitch_at, input int en_at, input int en_len,
                           output int lat, output int busy_cnt);
        Sign = sgn; Dividend = dvd; Divisor = dvs; Start = 1'b1;
        tick();
        Start = 1'b0; Dividend = 32'hDEAD_BEEF; Divisor = 32'h0000_0003;
        lat = 0;
        busy_cnt = Busy ? 1 : 0;
        while (!Done && lat < 100) begin
            Start = (glitch_at > 0 && lat == glitch_at);
            En    = !(en_len > 0 && lat >= en_at && lat < en_at + en_len);
            tick();
            lat++;
            if (Busy) busy_cnt++;
        end
        Start = 1'b0;
        En    = 1'b1;
    endtask

    int lat, bc, dones;

    initial begin
        Reset = 1'b1; En = 1'b1; Start = 1'b0; Sign = 1'b0;
        Dividend = '0; Divisor = '0;
        tick(); tick();
        check_eq("rst_busy", {31'b0, Busy}, 32'd0);
        check_eq("rst_done", {31'b0, Done}, 32'd0);
        check_eq("rst_quot", Quotient, 32'd0);
        check_eq("rst_rem",  Remainder, 32'd0);
        check_eq("rst_dz",   {31'b0, DivZero}, 32'd0);
        Reset = 1'b0;
        tick();

        run_div(1'b0, 32'd100, 32'd7, 0, 0, 0, lat, bc);
        check_eq("u100_7_lat",  32'(lat), 32'd34);
        check_eq("u100_7_busy", 32'(bc), 32'd34);
        check_eq("u100_7_q",    Quotient, 32'd14);
        check_eq("u100_7_r",    Remainder, 32'd2);
        check_eq("u100_7_dz",   {31'b0, DivZero}, 32'd0);
        tick();
        check_eq("done_pulse",  {31'b0, Done}, 32'd0);

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, lat, bc);
        check_eq("sm7_2_q", Quotient, 32'hFFFF_FFFD);
        check_eq("sm7_2_r", Remainder, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, lat, bc);
        check_eq("s7_m2_q", Quotient, 32'hFFFF_FFFD);
        check_eq("s7_m2_r", Remainder, 32'd1);

        run_div(1'b0, 32'h1234_5678, 32'd0, 0, 0, 0, lat, bc);
        check_eq("dz_lat", 32'(lat), 32'd34);
        check_eq("dz_q",   Quotient, 32'hFFFF_FFFF);
        check_eq("dz_r",   Remainder, 32'h1234_5678);
        check_eq("dz_flag", {31'b0, DivZero}, 32'd1);
        run_div(1'b1, 32'd9, 32'd3, 0, 0, 0, lat, bc);
        check_eq("dz_clear", {31'b0, DivZero}, 32'd0);
        check_eq("s9_3_q",   Quotient, 32'd3);

        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, lat, bc);
        check_eq("sovf_q", Quotient, 32'h8000_0000);
        check_eq("sovf_r", Remainder, 32'd0);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, lat, bc);
        check_eq("uovf_q", Quotient, 32'd0);
        check_eq("uovf_r", Remainder, 32'h8000_0000);

        // Stray Start mid-run, then back-to-back start from the DONE cycle
        run_div(1'b0, 32'd1000, 32'd10, 10, 0, 0, lat, bc);
        check_eq("glitch_lat", 32'(lat), 32'd34);
        check_eq("glitch_q",   Quotient, 32'd100);
        check_eq("glitch_r",   Remainder, 32'd0);
        check_eq("b2b_in_done", {31'b0, Done}, 32'd1);
        run_div(1'b0, 32'd50, 32'd3, 0, 0, 0, lat, bc);
        check_eq("b2b_lat", 32'(lat), 32'd34);
        check_eq("b2b_q",   Quotient, 32'd16);
        check_eq("b2b_r",   Remainder, 32'd2);

        run_div(1'b0, 32'd77, 32'd5, 0, 15, 5, lat, bc);
        check_eq("en_lat", 32'(lat), 32'd39);
        check_eq("en_q",   Quotient, 32'd15);
        check_eq("en_r",   Remainder, 32'd2);

        // Abort at cycle 20 of an operation
        tick(); tick();
        Sign = 1'b0; Dividend = 32'd500; Divisor = 32'd4; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (19) tick();
        Reset = 1'b1;
        #1;
        check_eq("abort_busy", {31'b0, Busy}, 32'd0);
        check_eq("abort_done", {31'b0, Done}, 32'd0);
        check_eq("abort_quot", Quotient, 32'd0);
        check_eq("abort_rem",  Remainder, 32'd0);
        tick();
        Reset = 1'b0;
        dones = 0;
        repeat (40) begin
            tick();
            if (Done) dones++;
        end
        check_eq("abort_no_done", 32'(dones), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
